// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
// The master drives the request and operands, and the slave returns the status and the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor that computes diff = a - b, LSB first.
// It uses one full-subtractor cell, a borrow flop and a start/busy/done frame.
//
// state  | meaning
// S_IDLE | waiting for start; result registers hold the last completion
// S_RUN  | one difference bit per edge, WIDTH edges total
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_borrow_nxt;
    logic             w_last;

    assign w_a0         = r_a[0];
    assign w_b0         = r_b[0];
    assign w_d          = w_a0 ^ w_b0 ^ r_borrow;
    assign w_borrow_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
    assign w_last       = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_r      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_r      <= {w_d, r_r[WIDTH-1:1]};
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    // The last bit goes straight into diff, so it never shows a partial value.
                    if (w_last) begin
                        r_diff  <= {w_d, r_r[WIDTH-1:1]};
                        r_bout  <= w_borrow_nxt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with an 8-bit instance (directed, table and random tests)
// and a 4-bit instance that is checked against every operand pair.
module tb_serial_subtractor;
    localparam int W  = 8;
    localparam int W4 = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(W))  bus8 ();
    serial_subtractor_if #(.WIDTH(W4)) bus4 ();

    serial_subtractor #(.WIDTH(W))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(W4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic and an unsigned comparison.
    function automatic logic [31:0] ref_diff(input int ra, input int rb, input int w);
        return 32'((ra - rb) & ((1 << w) - 1));
    endfunction

    function automatic logic [31:0] ref_bout(input int ra, input int rb);
        return (ra < rb) ? 32'd1 : 32'd0;
    endfunction

    // Pulses start for one operand pair, then returns at the first sample where done is high.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input string nm);
        int n;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = ta;
        bus8.b     = tb_v;
        @(posedge clk); #1;
        chk({nm, "_busy_accept"}, 32'(bus8.busy), 32'd1);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!bus8.done) begin
                bus8.a = 8'($urandom);
                bus8.b = 8'($urandom);
            end
        end while (!bus8.done && n < 3 * W);
        chk({nm, "_latency"}, 32'(n), 32'(W));
        chk({nm, "_busy_done"}, 32'(bus8.busy), 32'd0);
        chk({nm, "_diff"}, 32'(bus8.diff), ref_diff(int'(ta), int'(tb_v), W));
        chk({nm, "_bout"}, 32'(bus8.bout), ref_bout(int'(ta), int'(tb_v)));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] ea;
        logic [7:0] eb;
        int         c;
        int         ops;
        int         n;
        logic       seen;

        checks = 0;
        errors = 0;
        vecs[0] = '{8'd200,  8'd55,   8'h91, 1'b0};
        vecs[1] = '{8'd55,   8'd200,  8'h6F, 1'b1};
        vecs[2] = '{8'h00,   8'h01,   8'hFF, 1'b1};
        vecs[3] = '{8'h80,   8'h80,   8'h00, 1'b0};
        vecs[4] = '{8'h00,   8'h00,   8'h00, 1'b0};
        vecs[5] = '{8'hFF,   8'h00,   8'hFF, 1'b0};

        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        #23;
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_diff", 32'(bus8.diff), 32'd0);
        chk("rst_bout", 32'(bus8.bout), 32'd0);
        chk("rst_diff4", 32'(bus4.diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_diff", i), 32'(bus8.diff), 32'(vecs[i].exp_diff));
            chk($sformatf("vec%0d_tbl_bout", i), 32'(bus8.bout), 32'(vecs[i].exp_bout));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), 32'(bus8.done), 32'd0);
            chk($sformatf("vec%0d_hold", i), 32'(bus8.diff), 32'(vecs[i].exp_diff));
        end

        // Start held high for three operations, with the operands changing every cycle.
        @(negedge clk);
        bus8.start = 1'b1;
        ea = 8'($urandom);
        eb = 8'($urandom);
        bus8.a = ea;
        bus8.b = eb;
        qa.push_back(ea);
        qb.push_back(eb);
        c   = 0;
        ops = 0;
        while (ops < 3 && c < 100) begin
            @(posedge clk); #1;
            c++;
            if (c % (W + 1) == 0) begin
                chk("hold_done", 32'(bus8.done), 32'd1);
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("hold_diff", 32'(bus8.diff), ref_diff(int'(ea), int'(eb), W));
                chk("hold_bout", 32'(bus8.bout), ref_bout(int'(ea), int'(eb)));
                ops++;
                if (ops == 3) begin
                    bus8.start = 1'b0;
                end else begin
                    ea = 8'($urandom);
                    eb = 8'($urandom);
                    bus8.a = ea;
                    bus8.b = eb;
                    qa.push_back(ea);
                    qb.push_back(eb);
                end
            end else begin
                chk("hold_no_done", 32'(bus8.done), 32'd0);
                bus8.a = 8'($urandom);
                bus8.b = 8'($urandom);
            end
        end
        chk("hold_ops", 32'(ops), 32'd3);
        repeat (2) @(posedge clk);

        // Back-to-back: the next operation is accepted on the done cycle.
        run_op(8'd10, 8'd3, "b2b_first");
        bus8.start = 1'b1;
        bus8.a     = 8'd3;
        bus8.b     = 8'd10;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        chk("b2b_busy", 32'(bus8.busy), 32'd1);
        for (int i = 0; i < W; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            chk("b2b_old_diff", 32'(bus8.diff), 32'd7);
            chk("b2b_no_done", 32'(bus8.done), 32'd0);
        end
        @(posedge clk); #1;
        chk("b2b_done", 32'(bus8.done), 32'd1);
        chk("b2b_diff", 32'(bus8.diff), 32'hF9);
        chk("b2b_bout", 32'(bus8.bout), 32'd1);

        // Reset asserted mid-run (at count 4), checked before any further clock edge.
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'hF0;
        bus8.b     = 8'h0F;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus8.busy), 32'd0);
        chk("abort_done", 32'(bus8.done), 32'd0);
        chk("abort_diff", 32'(bus8.diff), 32'd0);
        chk("abort_bout", 32'(bus8.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (bus8.done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op(8'hF0, 8'h0F, "after_abort");
        chk("after_abort_diff_const", 32'(bus8.diff), 32'hE1);

        // Random operands against the reference model.
        for (int i = 0; i < 30; i++) begin
            run_op(8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
        end

        // Every operand pair on the 4-bit instance.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                @(negedge clk);
                bus4.start = 1'b1;
                bus4.a     = 4'(ia);
                bus4.b     = 4'(ib);
                @(posedge clk); #1;
                bus4.start = 1'b0;
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!bus4.done && n < 3 * W4);
                chk($sformatf("w4_lat_%0d_%0d", ia, ib), 32'(n), 32'(W4));
                chk($sformatf("w4_diff_%0d_%0d", ia, ib), 32'(bus4.diff), ref_diff(ia, ib, W4));
                chk($sformatf("w4_bout_%0d_%0d", ia, ib), 32'(bus4.bout), ref_bout(ia, ib));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
